fpu_responder: RTL and testbench

FPU-side responder for the decode stage's floating-point request interface. It accepts a one-cycle `StartF` request carrying `fp_operation`, operands and a destination tag, then executes a small set of single-precision operations with a state machine. It returns the result as a one-cycle `FPU_fp_we` write pulse, together with `fp_wdata` and the destination tag, to the FP register file. `fpu_busy` stays high for the whole operation so the hazard unit can stall the front end.

---
 rtl/fpu_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_fpu_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_responder.sv
// FP-side responder for decode-stage float requests: sign injection, min/max, move and int->float
// conversion, sequenced by a small FSM and returned as a one-cycle register-file write.
module fpu_responder #(
   parameter int unsigned FLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            StartF,
   input  logic [3:0]      fp_operation,
   input  logic [FLEN-1:0] fp_rs1_data,
   input  logic [FLEN-1:0] fp_rs2_data,
   input  logic [4:0]      fp_rd_in,
   output logic            FPU_fp_we,
   output logic [FLEN-1:0] fp_wdata,
   output logic [4:0]      fp_rd_out,
   output logic [4:0]      fflags,
   output logic            fpu_busy
);

   localparam int unsigned OPW  = 4;
   localparam int unsigned REGW = 5;
   localparam int unsigned LZW  = 5;
   localparam logic [FLEN-1:0] QNAN = 32'h7FC0_0000;

   localparam logic [OPW-1:0] OP_FSGNJ  = 4'd0;
   localparam logic [OPW-1:0] OP_FSGNJN = 4'd1;
   localparam logic [OPW-1:0] OP_FSGNJX = 4'd2;
   localparam logic [OPW-1:0] OP_FMIN   = 4'd3;
   localparam logic [OPW-1:0] OP_FMAX   = 4'd4;
   localparam logic [OPW-1:0] OP_FMV    = 4'd5;
   localparam logic [OPW-1:0] OP_CVTW   = 4'd6;
   localparam logic [OPW-1:0] OP_CVTWU  = 4'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [OPW-1:0]  op_q, op_d;
   logic [FLEN-1:0] a_q, a_d, b_q, b_d;
   logic [REGW-1:0] rd_q, rd_d;
   logic [FLEN-1:0] mag_q, mag_d;
   logic            sign_q, sign_d;
   logic [LZW-1:0]  lz_q, lz_d;
   logic [FLEN-1:0] wdata_q, wdata_d;
   logic [REGW-1:0] rd_out_q, rd_out_d;
   logic [4:0]      fflags_q, fflags_d;
   logic            we_q, we_d;
   logic            busy_q, busy_d;

   // Single-cycle operations
   logic            nan_a, nan_b, snan_a, snan_b, a_lt_b;
   logic [FLEN-1:0] simple_res;
   logic [4:0]      simple_flags;

   always_comb begin
      nan_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
      nan_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
      snan_a = nan_a & ~a_q[22];
      snan_b = nan_b & ~b_q[22];
      // Sign-magnitude ordering; differing signs also order -0 below +0
      if (a_q[31] != b_q[31])
         a_lt_b = a_q[31];
      else if (!a_q[31])
         a_lt_b = a_q[30:0] < b_q[30:0];
      else
         a_lt_b = a_q[30:0] > b_q[30:0];

      simple_res   = QNAN;
      simple_flags = 5'b10000;
      case (op_q)
         OP_FSGNJ: begin
            simple_res   = {b_q[31], a_q[30:0]};
            simple_flags = 5'b00000;
         end
         OP_FSGNJN: begin
            simple_res   = {~b_q[31], a_q[30:0]};
            simple_flags = 5'b00000;
         end
         OP_FSGNJX: begin
            simple_res   = {a_q[31] ^ b_q[31], a_q[30:0]};
            simple_flags = 5'b00000;
         end
         OP_FMIN, OP_FMAX: begin
            simple_flags = {snan_a | snan_b, 4'b0000};
            if (nan_a && nan_b)
               simple_res = QNAN;
            else if (nan_a)
               simple_res = b_q;
            else if (nan_b)
               simple_res = a_q;
            else if (op_q == OP_FMIN)
               simple_res = a_lt_b ? a_q : b_q;
            else
               simple_res = a_lt_b ? b_q : a_q;
         end
         OP_FMV: begin
            simple_res   = a_q;
            simple_flags = 5'b00000;
         end
         default: begin
            simple_res   = QNAN;
            simple_flags = 5'b10000;
         end
      endcase
   end

   // Conversion front end and round-to-nearest-even packing
   logic            is_cvt, cvt_sign;
   logic [FLEN-1:0] cvt_mag;
   logic [22:0]     mant_raw;
   logic            rnd_g, rnd_s, rnd_inc;
   logic [23:0]     mant_sum;
   logic [7:0]      exp_r;
   logic [FLEN-1:0] round_res;

   always_comb begin
      is_cvt    = (op_q == OP_CVTW) || (op_q == OP_CVTWU);
      cvt_sign  = (op_q == OP_CVTW) & a_q[31];
      cvt_mag   = cvt_sign ? (~a_q + 32'd1) : a_q;
      mant_raw  = mag_q[30:8];
      rnd_g     = mag_q[7];
      rnd_s     = |mag_q[6:0];
      rnd_inc   = rnd_g & (rnd_s | mant_raw[0]);
      mant_sum  = {1'b0, mant_raw} + 24'(rnd_inc);
      exp_r     = 8'(8'd158 - 8'(lz_q)) + 8'(mant_sum[23]);
      round_res = {sign_q, exp_r, mant_sum[22:0]};
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      rd_d     = rd_q;
      mag_d    = mag_q;
      sign_d   = sign_q;
      lz_d     = lz_q;
      wdata_d  = wdata_q;
      rd_out_d = rd_out_q;
      fflags_d = fflags_q;
      we_d     = 1'b0;
      busy_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (StartF) begin
               op_d    = fp_operation;
               a_d     = fp_rs1_data;
               b_d     = fp_rs2_data;
               rd_d    = fp_rd_in;
               lz_d    = '0;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_cvt) begin
               sign_d = cvt_sign;
               mag_d  = cvt_mag;
               if (cvt_mag == '0) begin
                  wdata_d  = '0;
                  fflags_d = 5'b00000;
                  state_d  = S_DONE;
               end else begin
                  state_d = cvt_mag[31] ? S_ROUND : S_NORM;
               end
            end else begin
               wdata_d  = simple_res;
               fflags_d = simple_flags;
               state_d  = S_DONE;
            end
         end
         S_NORM: begin
            mag_d = mag_q << 1;
            lz_d  = lz_q + 5'd1;
            if (mag_q[30])
               state_d = S_ROUND;
         end
         S_ROUND: begin
            wdata_d  = round_res;
            fflags_d = {4'b0000, rnd_g | rnd_s};
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      we_d   = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
      if (we_d)
         rd_out_d = rd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rd_q     <= '0;
         mag_q    <= '0;
         sign_q   <= 1'b0;
         lz_q     <= '0;
         wdata_q  <= '0;
         rd_out_q <= '0;
         fflags_q <= '0;
         we_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rd_q     <= rd_d;
         mag_q    <= mag_d;
         sign_q   <= sign_d;
         lz_q     <= lz_d;
         wdata_q  <= wdata_d;
         rd_out_q <= rd_out_d;
         fflags_q <= fflags_d;
         we_q     <= we_d;
         busy_q   <= busy_d;
      end
   end

   assign FPU_fp_we = we_q;
   assign fp_wdata  = wdata_q;
   assign fp_rd_out = rd_out_q;
   assign fflags    = fflags_q;
   assign fpu_busy  = busy_q;

endmodule

// File: tb/tb_fpu_responder.sv
// Directed bench for fpu_responder: hand-computed results, flags, latency, busy length and
// write-pulse counts per request, plus reset abort and request-while-busy handling.
module tb_fpu_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  op_i;
   logic [31:0] a_i, b_i;
   logic [4:0]  rd_i;
   logic        we;
   logic [31:0] wdata;
   logic [4:0]  rd_o;
   logic [4:0]  flags;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   fpu_responder #(.FLEN(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .StartF       (start),
      .fp_operation (op_i),
      .fp_rs1_data  (a_i),
      .fp_rs2_data  (b_i),
      .fp_rd_in     (rd_i),
      .FPU_fp_we    (we),
      .fp_wdata     (wdata),
      .fp_rd_out    (rd_o),
      .fflags       (flags),
      .fpu_busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   // Issue one request, then follow it until busy drops (bounded)
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit poke,
                         output int we_edge, output int busy_cnt, output int pulses,
                         output int b2b, output logic [31:0] wd, output logic [4:0] fl,
                         output logic [4:0] rdo);
      bit prev, done;
      we_edge = -1; busy_cnt = 0; pulses = 0; b2b = 0;
      wd = 'x; fl = 'x; rdo = 'x;
      prev = 1'b0; done = 1'b0;
      @(negedge clk);
      start = 1'b1; op_i = op; a_i = a; b_i = b; rd_i = rd;
      @(posedge clk); #1;
      for (int j = 0; j < 64 && !done; j++) begin
         if (j > 0) begin
            @(posedge clk); #1;
         end
         if (busy) busy_cnt++;
         if (we) begin
            pulses++;
            if (prev) b2b++;
            we_edge = j;
            wd = wdata; fl = flags; rdo = rd_o;
         end
         prev = we;
         if (!busy) done = 1'b1;
         start = poke && busy;
         if (poke) begin
            op_i = 4'(j); a_i = 32'h0000_0001; rd_i = 5'd31;
         end
      end
      start = 1'b0;
      check("terminated", 32'(done), 32'd1);
   endtask

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a, b, res;
      logic [4:0]  fl;
      int          lat;
      bit          poke;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int we_edge, busy_cnt, pulses, b2b, extra;
      logic [31:0] wd;
      logic [4:0]  fl, rdo;

      rst_n = 1'b0; start = 1'b0; op_i = '0; a_i = '0; b_i = '0; rd_i = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_we",    32'(we),    32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_wdata", wdata,      32'd0);
      check("rst_rd",    32'(rd_o),  32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      vecs.push_back('{"fsgnjn",     4'd1,  32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000, 5'b00000, 2,  1'b0});
      vecs.push_back('{"fsgnjx",     4'd2,  32'hC000_0000, 32'hBF80_0000, 32'h4000_0000, 5'b00000, 2,  1'b0});
      vecs.push_back('{"fmv",        4'd5,  32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 5'b00000, 2,  1'b0});
      vecs.push_back('{"fmin_zero",  4'd3,  32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 5'b00000, 2,  1'b0});
      vecs.push_back('{"fmax_zero",  4'd4,  32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 5'b00000, 2,  1'b0});
      vecs.push_back('{"fmax_qnan",  4'd4,  32'h7FC0_0000, 32'h4000_0000, 32'h4000_0000, 5'b00000, 2,  1'b0});
      vecs.push_back('{"fmax_snan",  4'd4,  32'h7F80_0001, 32'h4000_0000, 32'h4000_0000, 5'b10000, 2,  1'b0});
      vecs.push_back('{"fmin_2nan",  4'd3,  32'h7FC0_0000, 32'h7F80_0001, 32'h7FC0_0000, 5'b10000, 2,  1'b0});
      vecs.push_back('{"fmin_neg",   4'd3,  32'hC000_0000, 32'hBF80_0000, 32'hC000_0000, 5'b00000, 2,  1'b0});
      vecs.push_back('{"cvtw_1",     4'd6,  32'h0000_0001, 32'h0,         32'h3F80_0000, 5'b00000, 34, 1'b0});
      vecs.push_back('{"cvtw_m1",    4'd6,  32'hFFFF_FFFF, 32'h0,         32'hBF80_0000, 5'b00000, 34, 1'b0});
      vecs.push_back('{"cvtw_m3",    4'd6,  32'hFFFF_FFFD, 32'h0,         32'hC040_0000, 5'b00000, 33, 1'b0});
      vecs.push_back('{"cvtw_min",   4'd6,  32'h8000_0000, 32'h0,         32'hCF00_0000, 5'b00000, 3,  1'b0});
      vecs.push_back('{"cvtwu_tie",  4'd7,  32'h0100_0001, 32'h0,         32'h4B80_0000, 5'b00001, 10, 1'b0});
      vecs.push_back('{"cvtwu_up",   4'd7,  32'h0100_0003, 32'h0,         32'h4B80_0002, 5'b00001, 10, 1'b0});
      vecs.push_back('{"cvtwu_max",  4'd7,  32'hFFFF_FFFF, 32'h0,         32'h4F80_0000, 5'b00001, 3,  1'b0});
      vecs.push_back('{"cvtwu_zero", 4'd7,  32'h0000_0000, 32'h0,         32'h0000_0000, 5'b00000, 2,  1'b0});
      vecs.push_back('{"illegal_12", 4'd12, 32'h3F80_0000, 32'h0,         32'h7FC0_0000, 5'b10000, 2,  1'b1});
      vecs.push_back('{"cvtw_poke",  4'd6,  32'h0000_0100, 32'h0,         32'h4380_0000, 5'b00000, 26, 1'b1});

      foreach (vecs[i]) begin
         logic [4:0] tag;
         tag = 5'(i + 3);
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, tag, vecs[i].poke,
                we_edge, busy_cnt, pulses, b2b, wd, fl, rdo);
         check({vecs[i].name, "_wdata"},   wd,              vecs[i].res);
         check({vecs[i].name, "_flags"},   32'(fl),         32'(vecs[i].fl));
         check({vecs[i].name, "_rd"},      32'(rdo),        32'(tag));
         check({vecs[i].name, "_latency"}, 32'(we_edge + 1), 32'(vecs[i].lat));
         check({vecs[i].name, "_busy"},    32'(busy_cnt),   32'(vecs[i].lat));
         check({vecs[i].name, "_pulses"},  32'(pulses),     32'd1);
         check({vecs[i].name, "_b2b"},     32'(b2b),        32'd0);
         extra = 0;
         repeat (3) begin
            @(posedge clk); #1;
            if (we || busy) extra++;
         end
         check({vecs[i].name, "_quiet"},   32'(extra),      32'd0);
         check({vecs[i].name, "_hold"},    wdata,           vecs[i].res);
      end

      // Abort a long conversion with reset while it is normalizing
      @(negedge clk);
      start = 1'b1; op_i = 4'd7; a_i = 32'h0000_0001; rd_i = 5'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_we",    32'(we),    32'd0);
      check("abort_busy",  32'(busy),  32'd0);
      check("abort_wdata", wdata,      32'd0);
      check("abort_rd",    32'(rd_o),  32'd0);
      check("abort_flags", 32'(flags), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (we || busy) extra++;
      end
      check("abort_no_write", 32'(extra), 32'd0);

      run_op(4'd0, 32'h3F80_0000, 32'h8000_0000, 5'd17, 1'b0,
             we_edge, busy_cnt, pulses, b2b, wd, fl, rdo);
      check("post_rst_wdata",   wd,               32'hBF80_0000);
      check("post_rst_rd",      32'(rdo),         32'd17);
      check("post_rst_flags",   32'(fl),          32'd0);
      check("post_rst_latency", 32'(we_edge + 1), 32'd2);
      check("post_rst_pulses",  32'(pulses),      32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
